// File: rtl/uart_tx_arbiter_if.sv
// Bus between the UART transmit arbiter, its byte requesters and the UART transmitter.
// master = arbiter side, slave = requesters plus UART.
interface uart_tx_arbiter_if #(
    parameter int NREQ = 2
);
    logic [NREQ-1:0]   req_valid;
    logic [8*NREQ-1:0] req_data;
    logic [NREQ-1:0]   req_ready;
    logic              uart_we;
    logic              uart_en;
    logic [7:0]        uart_data;
    logic              uart_tx_busy;
    logic              uart_tx_done;
    logic [1:0]        grant_id;
    logic              busy;

    modport master (
        input  req_valid, req_data, uart_tx_busy, uart_tx_done,
        output req_ready, uart_we, uart_en, uart_data, grant_id, busy
    );

    modport slave (
        output req_valid, req_data, uart_tx_busy, uart_tx_done,
        input  req_ready, uart_we, uart_en, uart_data, grant_id, busy
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NREQ byte requesters.
// Optional watchdog: define UART_TX_ARBITER_TIMEOUT_EN to add timeout_err and the transfer timer.
//
// state       | meaning
// S_IDLE      | no transfer; arbitrate, then one cycle with req_ready pulsed
// S_LAUNCH    | uart_we high with the held byte until the UART reports busy
// S_WAIT_DONE | byte in flight; wait for uart_tx_done
module uart_tx_arbiter #(
    parameter int NREQ           = 2,
    parameter int TIMEOUT_CYCLES = 200000
) (
    input  logic                     clk,
    input  logic                     rst_n,
    uart_tx_arbiter_if.master        bus
`ifdef UART_TX_ARBITER_TIMEOUT_EN
    ,
    output logic                     timeout_err
`endif
);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_LAUNCH    = 2'd1,
        S_WAIT_DONE = 2'd2
    } state_t;

    state_t          r_state;
    logic [1:0]      r_ptr;
    logic [7:0]      r_hold;
    logic [NREQ-1:0] r_req_ready;
    logic            r_uart_we;
    logic            r_uart_en;
    logic [7:0]      r_uart_data;
    logic [1:0]      r_grant;
    logic            r_busy;

    logic            w_any;
    logic [NREQ-1:0] w_rot;
    logic [1:0]      w_off;
    logic [1:0]      w_winner;
    logic [1:0]      w_ptr_nxt;
    logic [NREQ-1:0] w_grant_vec;
    logic [7:0]      w_data;
    logic            w_to_hit;

    function automatic logic [1:0] f_wrap(input logic [2:0] s);
        if (s >= 3'(NREQ))
            return 2'(s - 3'(NREQ));
        else
            return s[1:0];
    endfunction

    // w_rot[k] is the request k positions above the round-robin pointer
    always_comb begin
        w_any       = |bus.req_valid;
        w_rot       = '0;
        w_off       = 2'd0;
        w_grant_vec = '0;
        w_data      = 8'h00;
        for (int k = 0; k < NREQ; k++) begin
            for (int j = 0; j < NREQ; j++) begin
                if (f_wrap({1'b0, r_ptr} + 3'(k)) == 2'(j))
                    w_rot[k] = bus.req_valid[j];
            end
        end
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (w_rot[k])
                w_off = 2'(k);
        end
        w_winner  = f_wrap({1'b0, r_ptr} + {1'b0, w_off});
        w_ptr_nxt = f_wrap({1'b0, w_winner} + 3'd1);
        for (int k = 0; k < NREQ; k++) begin
            if (w_winner == 2'(k)) begin
                w_grant_vec[k] = 1'b1;
                w_data         = bus.req_data[8*k +: 8];
            end
        end
    end

`ifdef UART_TX_ARBITER_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] r_cnt;
    logic          r_timeout_err;

    assign w_to_hit    = (r_cnt == CNT_LAST);
    assign timeout_err = r_timeout_err;
`else
    assign w_to_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_ptr       <= 2'd0;
            r_hold      <= 8'h00;
            r_req_ready <= '0;
            r_uart_we   <= 1'b0;
            r_uart_en   <= 1'b0;
            r_uart_data <= 8'h00;
            r_grant     <= 2'd0;
            r_busy      <= 1'b0;
`ifdef UART_TX_ARBITER_TIMEOUT_EN
            r_cnt         <= '0;
            r_timeout_err <= 1'b0;
`endif
        end else begin
            r_uart_en   <= 1'b1;
            r_req_ready <= '0;
`ifdef UART_TX_ARBITER_TIMEOUT_EN
            r_timeout_err <= 1'b0;
            r_cnt         <= r_cnt + 1'b1;
`endif
            case (r_state)
                S_IDLE: begin
                    // A set req_ready marks the accept cycle; launch follows it
                    if (r_req_ready != '0) begin
                        r_state     <= S_LAUNCH;
                        r_uart_we   <= 1'b1;
                        r_uart_data <= r_hold;
                        r_busy      <= 1'b1;
`ifdef UART_TX_ARBITER_TIMEOUT_EN
                        r_cnt <= '0;
`endif
                    end else if (w_any) begin
                        r_req_ready <= w_grant_vec;
                        r_hold      <= w_data;
                        r_grant     <= w_winner;
                        r_ptr       <= w_ptr_nxt;
                    end
                end
                S_LAUNCH: begin
                    if (w_to_hit) begin
                        r_state   <= S_IDLE;
                        r_uart_we <= 1'b0;
                        r_busy    <= 1'b0;
`ifdef UART_TX_ARBITER_TIMEOUT_EN
                        r_timeout_err <= 1'b1;
`endif
                    end else if (bus.uart_tx_busy) begin
                        r_state   <= S_WAIT_DONE;
                        r_uart_we <= 1'b0;
                    end
                end
                S_WAIT_DONE: begin
                    if (w_to_hit) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
`ifdef UART_TX_ARBITER_TIMEOUT_EN
                        r_timeout_err <= 1'b1;
`endif
                    end else if (bus.uart_tx_done) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state   <= S_IDLE;
                    r_uart_we <= 1'b0;
                    r_busy    <= 1'b0;
                end
            endcase
        end
    end

    assign bus.req_ready = r_req_ready;
    assign bus.uart_we   = r_uart_we;
    assign bus.uart_en   = r_uart_en;
    assign bus.uart_data = r_uart_data;
    assign bus.grant_id  = r_grant;
    assign bus.busy      = r_busy;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: vector table plus reset and watchdog sequences.
// The watchdog sequence is built only when UART_TX_ARBITER_TIMEOUT_EN is defined.
module tb_uart_tx_arbiter;

    logic clk;
    logic rst_n;
`ifdef UART_TX_ARBITER_TIMEOUT_EN
    logic timeout_err;
`endif

    uart_tx_arbiter_if #(.NREQ(2)) bus ();

    uart_tx_arbiter #(
        .NREQ           (2),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus.master)
`ifdef UART_TX_ARBITER_TIMEOUT_EN
        ,
        .timeout_err (timeout_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [1:0] valid;
        logic [7:0] d0;
        logic [7:0] d1;
        logic       txb;
        logic       txd;
        logic [1:0] ready;
        logic       we;
        logic [7:0] data;
        logic [1:0] gid;
        logic       bsy;
    } vec_t;

    vec_t vecs[64];
    int   nv;
    int   checks;
    int   failures;

    task automatic add(input string name, input logic [1:0] valid, input logic [7:0] d0,
                       input logic [7:0] d1, input logic txb, input logic txd,
                       input logic [1:0] ready, input logic we, input logic [7:0] data,
                       input logic [1:0] gid, input logic bsy);
        vecs[nv].name  = name;
        vecs[nv].valid = valid;
        vecs[nv].d0    = d0;
        vecs[nv].d1    = d1;
        vecs[nv].txb   = txb;
        vecs[nv].txd   = txd;
        vecs[nv].ready = ready;
        vecs[nv].we    = we;
        vecs[nv].data  = data;
        vecs[nv].gid   = gid;
        vecs[nv].bsy   = bsy;
        nv++;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_outs(input string name, input logic [1:0] ready, input logic we,
                            input logic [7:0] data, input logic [1:0] gid, input logic bsy,
                            input logic en);
        chk({name, ".req_ready"}, 32'(bus.req_ready), 32'(ready));
        chk({name, ".uart_we"},   32'(bus.uart_we),   32'(we));
        chk({name, ".uart_data"}, 32'(bus.uart_data), 32'(data));
        chk({name, ".grant_id"},  32'(bus.grant_id),  32'(gid));
        chk({name, ".busy"},      32'(bus.busy),      32'(bsy));
        chk({name, ".uart_en"},   32'(bus.uart_en),   32'(en));
    endtask

    task automatic drive(input logic [1:0] valid, input logic [7:0] d0, input logic [7:0] d1,
                         input logic txb, input logic txd);
        bus.req_valid    = valid;
        bus.req_data     = {d1, d0};
        bus.uart_tx_busy = txb;
        bus.uart_tx_done = txd;
    endtask

    logic [7:0] seq_byte [4];
    logic [1:0] seq_gid  [4];
    logic [7:0] prev;

    initial begin
        checks   = 0;
        failures = 0;
        nv       = 0;
        rst_n    = 1'b0;
        drive(2'b00, 8'h00, 8'h00, 1'b0, 1'b0);

        // Two requesters held valid: strict alternation starting at requester 0
        seq_byte[0] = 8'hA0; seq_gid[0] = 2'd0;
        seq_byte[1] = 8'hB1; seq_gid[1] = 2'd1;
        seq_byte[2] = 8'hA0; seq_gid[2] = 2'd0;
        seq_byte[3] = 8'hB1; seq_gid[3] = 2'd1;
        prev = 8'h00;
        for (int b = 0; b < 4; b++) begin
            add("rr_grant",  2'b11, 8'hA0, 8'hB1, 1'b0, 1'b0,
                (seq_gid[b] == 2'd0) ? 2'b01 : 2'b10, 1'b0, prev, seq_gid[b], 1'b0);
            add("rr_launch", 2'b11, 8'hA0, 8'hB1, 1'b0, 1'b0, 2'b00, 1'b1, seq_byte[b], seq_gid[b], 1'b1);
            add("rr_wait",   2'b11, 8'hA0, 8'hB1, 1'b1, 1'b0, 2'b00, 1'b0, seq_byte[b], seq_gid[b], 1'b1);
            add("rr_done",   2'b11, 8'hA0, 8'hB1, 1'b0, 1'b1, 2'b00, 1'b0, seq_byte[b], seq_gid[b], 1'b0);
            prev = seq_byte[b];
        end
        // tx_done coincident with a new request: one idle cycle before the grant
        add("cd_grant0",   2'b01, 8'hC3, 8'hB1, 1'b0, 1'b0, 2'b01, 1'b0, 8'hB1, 2'd0, 1'b0);
        add("cd_launch0",  2'b00, 8'hC3, 8'hB1, 1'b0, 1'b0, 2'b00, 1'b1, 8'hC3, 2'd0, 1'b1);
        add("cd_wait0",    2'b00, 8'hC3, 8'hB1, 1'b1, 1'b0, 2'b00, 1'b0, 8'hC3, 2'd0, 1'b1);
        add("cd_done_req", 2'b10, 8'hC3, 8'hB1, 1'b0, 1'b1, 2'b00, 1'b0, 8'hC3, 2'd0, 1'b0);
        add("cd_grant1",   2'b10, 8'hC3, 8'hB1, 1'b0, 1'b0, 2'b10, 1'b0, 8'hC3, 2'd1, 1'b0);
        add("cd_drop_v",   2'b00, 8'hC3, 8'hB1, 1'b0, 1'b1, 2'b00, 1'b1, 8'hB1, 2'd1, 1'b1);
        add("cd_done_lau", 2'b00, 8'hC3, 8'hB1, 1'b0, 1'b1, 2'b00, 1'b1, 8'hB1, 2'd1, 1'b1);
        add("cd_wait1",    2'b00, 8'hC3, 8'hB1, 1'b1, 1'b0, 2'b00, 1'b0, 8'hB1, 2'd1, 1'b1);
        add("cd_done1",    2'b00, 8'hC3, 8'hB1, 1'b0, 1'b1, 2'b00, 1'b0, 8'hB1, 2'd1, 1'b0);
        // Single requester 0x55 with a slow busy response
        add("s_grant",  2'b01, 8'h55, 8'h00, 1'b0, 1'b0, 2'b01, 1'b0, 8'hB1, 2'd0, 1'b0);
        add("s_launch", 2'b00, 8'h55, 8'h00, 1'b0, 1'b0, 2'b00, 1'b1, 8'h55, 2'd0, 1'b1);
        add("s_hold",   2'b00, 8'h55, 8'h00, 1'b0, 1'b0, 2'b00, 1'b1, 8'h55, 2'd0, 1'b1);
        add("s_busy",   2'b00, 8'h55, 8'h00, 1'b1, 1'b0, 2'b00, 1'b0, 8'h55, 2'd0, 1'b1);
        add("s_busy2",  2'b00, 8'h55, 8'h00, 1'b1, 1'b0, 2'b00, 1'b0, 8'h55, 2'd0, 1'b1);
        add("s_done",   2'b00, 8'h55, 8'h00, 1'b0, 1'b1, 2'b00, 1'b0, 8'h55, 2'd0, 1'b0);
        add("s_idle",   2'b00, 8'h55, 8'h00, 1'b0, 1'b0, 2'b00, 1'b0, 8'h55, 2'd0, 1'b0);

        #3;
        chk_outs("reset", 2'b00, 1'b0, 8'h00, 2'd0, 1'b0, 1'b0);
`ifdef UART_TX_ARBITER_TIMEOUT_EN
        chk("reset.timeout_err", 32'(timeout_err), 32'd0);
`endif
        tick();
        rst_n = 1'b1;
        tick();
        chk_outs("post_reset", 2'b00, 1'b0, 8'h00, 2'd0, 1'b0, 1'b1);

        for (int i = 0; i < nv; i++) begin
            drive(vecs[i].valid, vecs[i].d0, vecs[i].d1, vecs[i].txb, vecs[i].txd);
            tick();
            chk_outs(vecs[i].name, vecs[i].ready, vecs[i].we, vecs[i].data, vecs[i].gid,
                     vecs[i].bsy, 1'b1);
        end

        // Reset during WAIT_DONE drops the byte and rewinds the pointer to 0
        drive(2'b01, 8'h11, 8'h00, 1'b0, 1'b0);
        tick();
        chk_outs("mr_grant", 2'b01, 1'b0, 8'h55, 2'd0, 1'b0, 1'b1);
        drive(2'b00, 8'h11, 8'h00, 1'b0, 1'b0);
        tick();
        drive(2'b00, 8'h11, 8'h00, 1'b1, 1'b0);
        tick();
        chk_outs("mr_wait", 2'b00, 1'b0, 8'h11, 2'd0, 1'b1, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_outs("mr_async", 2'b00, 1'b0, 8'h00, 2'd0, 1'b0, 1'b0);
        drive(2'b00, 8'h00, 8'h00, 1'b0, 1'b0);
        tick();
        chk_outs("mr_held", 2'b00, 1'b0, 8'h00, 2'd0, 1'b0, 1'b0);
        rst_n = 1'b1;
        tick();
        chk_outs("mr_release", 2'b00, 1'b0, 8'h00, 2'd0, 1'b0, 1'b1);
        drive(2'b11, 8'h22, 8'h33, 1'b0, 1'b0);
        tick();
        chk_outs("mr_ptr0", 2'b01, 1'b0, 8'h00, 2'd0, 1'b0, 1'b1);
        drive(2'b00, 8'h22, 8'h33, 1'b0, 1'b0);
        tick();
        chk_outs("mr_launch", 2'b00, 1'b1, 8'h22, 2'd0, 1'b1, 1'b1);
        drive(2'b00, 8'h22, 8'h33, 1'b1, 1'b0);
        tick();
        drive(2'b00, 8'h22, 8'h33, 1'b0, 1'b1);
        tick();
        // Pointer is now 1: with only requester 1 valid it wins
        drive(2'b10, 8'h22, 8'h44, 1'b0, 1'b0);
        tick();
        chk_outs("mr_req1", 2'b10, 1'b0, 8'h22, 2'd1, 1'b0, 1'b1);
        drive(2'b00, 8'h22, 8'h44, 1'b0, 1'b0);
        tick();
        chk_outs("mr_launch1", 2'b00, 1'b1, 8'h44, 2'd1, 1'b1, 1'b1);
        drive(2'b00, 8'h22, 8'h44, 1'b1, 1'b0);
        tick();
        drive(2'b00, 8'h22, 8'h44, 1'b0, 1'b1);
        tick();
        chk_outs("mr_idle", 2'b00, 1'b0, 8'h44, 2'd1, 1'b0, 1'b1);
        drive(2'b00, 8'h22, 8'h44, 1'b0, 1'b0);

`ifdef UART_TX_ARBITER_TIMEOUT_EN
        // UART never goes busy: watchdog fires 16 cycles after LAUNCH entry
        drive(2'b01, 8'h66, 8'h00, 1'b0, 1'b0);
        tick();
        drive(2'b00, 8'h66, 8'h00, 1'b0, 1'b0);
        tick();
        chk_outs("to_launch", 2'b00, 1'b1, 8'h66, 2'd0, 1'b1, 1'b1);
        for (int c = 1; c < 16; c++) begin
            tick();
            chk("to_quiet", 32'(timeout_err), 32'd0);
        end
        chk("to_still_busy", 32'(bus.busy), 32'd1);
        tick();
        chk("to_pulse", 32'(timeout_err), 32'd1);
        chk("to_idle", 32'(bus.busy), 32'd0);
        tick();
        chk("to_pulse_end", 32'(timeout_err), 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
